// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller.
// Also holds the condition-code evaluation helper.
package ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMRD    = 4'd3;
  localparam state_t S_MEMWR    = 4'd4;
  localparam state_t S_MEMWB    = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // flags are packed {N,Z,C,V}; the never-condition 1111 evaluates false
  function automatic logic condEval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic result;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: result = z;
      COND_NE: result = ~z;
      COND_CS: result = c;
      COND_CC: result = ~c;
      COND_MI: result = n;
      COND_PL: result = ~n;
      COND_VS: result = v;
      COND_VC: result = ~v;
      COND_HI: result = c & ~z;
      COND_LS: result = ~c | z;
      COND_GE: result = (n == v);
      COND_LT: result = (n != v);
      COND_GT: result = ~z & (n == v);
      COND_LE: result = z | (n != v);
      COND_AL: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/multicycle_control_cond.sv
// Conditional-execution unit: flags register, latched condition result and
// gating of the architectural write enables.
module multicycle_control_cond
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluFlags,
  input  logic [1:0] flagW,
  input  logic       condLoad,
  input  logic       condClear,
  input  logic       nextPC,
  input  logic       pcs,
  input  logic       regW,
  input  logic       memW,
  input  logic       noWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWrite
);

  logic [3:0] flags;
  logic       condExReg;
  logic       condEx;

  assign condEx = condEval(cond, flags);

  // condExReg is cleared after FETCH so a previous instruction's result never
  // gates the next one before its own DECODE has evaluated the condition
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= FLAGS_RESET;
      condExReg <= 1'b0;
    end else begin
      if (condLoad)
        condExReg <= condEx;
      else if (condClear)
        condExReg <= 1'b0;
      if (flagW[1] & condExReg)
        flags[3:2] <= aluFlags[3:2];
      if (flagW[0] & condExReg)
        flags[1:0] <= aluFlags[1:0];
    end
  end

  assign pcWrite  = nextPC | (pcs & condExReg);
  assign regWrite = regW & condExReg & ~noWrite;
  assign memWrite = memW & condExReg;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control unit: main FSM, instruction decode and ALU
// decode, with conditional execution delegated to multicycle_control_cond.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] instr,
  input  logic [3:0]  aluFlags,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        memWrite,
  output logic        regWrite,
  output logic        adrSrc,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluControl,
  output logic [1:0]  immSrc,
  output logic [1:0]  regSrc
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unusedRn;

  assign cond     = instr[19:16];
  assign op       = instr[15:14];
  assign funct    = instr[13:8];
  assign rd       = instr[3:0];
  assign unusedRn = ^instr[7:4];

  state_t state, nextState, curState;

  // while reset is high the selects must already look like FETCH
  assign curState = reset ? S_FETCH : state;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = S_FETCH;
    case (state)
      S_FETCH:  nextState = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  nextState = S_MEMADR;
          OP_DP:   nextState = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   nextState = S_BRANCH;
          default: nextState = S_FETCH;
        endcase
      end
      S_MEMADR:   nextState = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nextState = S_MEMWB;
      S_EXECUTER: nextState = S_ALUWB;
      S_EXECUTEI: nextState = S_ALUWB;
      default:    nextState = S_FETCH;
    endcase
  end

  logic irW, nextPC, branch, regW, memW, aluOp;

  always_comb begin
    irW       = 1'b0;
    nextPC    = 1'b0;
    branch    = 1'b0;
    regW      = 1'b0;
    memW      = 1'b0;
    aluOp     = 1'b0;
    adrSrc    = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    resultSrc = 2'b00;
    case (curState)
      S_FETCH: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irW       = 1'b1;
        nextPC    = 1'b1;
      end
      S_DECODE: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
      end
      S_MEMADR:   aluSrcB = 2'b01;
      S_BRANCH: begin
        aluSrcB   = 2'b01;
        resultSrc = 2'b10;
        branch    = 1'b1;
      end
      S_MEMRD:    adrSrc = 1'b1;
      S_MEMWR: begin
        adrSrc = 1'b1;
        memW   = 1'b1;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regW      = 1'b1;
      end
      S_EXECUTER: aluOp = 1'b1;
      S_EXECUTEI: begin
        aluSrcB = 2'b01;
        aluOp   = 1'b1;
      end
      S_ALUWB:    regW = 1'b1;
      default: ;
    endcase
  end

  assign irWrite = irW & ~reset;

  logic [1:0] flagW;
  logic       noWrite;
  logic       knownCmd;

  always_comb begin
    aluControl = ALU_ADD;
    flagW      = 2'b00;
    if (aluOp) begin
      case (funct[4:1])
        CMD_ADD: begin aluControl = ALU_ADD; flagW = {funct[0], funct[0]}; end
        CMD_SUB: begin aluControl = ALU_SUB; flagW = {funct[0], funct[0]}; end
        CMD_CMP: begin aluControl = ALU_SUB; flagW = {funct[0], funct[0]}; end
        CMD_AND: begin aluControl = ALU_AND; flagW = {funct[0], 1'b0}; end
        CMD_ORR: begin aluControl = ALU_ORR; flagW = {funct[0], 1'b0}; end
        default: ;
      endcase
    end
  end

  // noWrite follows the instruction rather than aluOp so it still blocks the
  // register write in ALUWB, where the ALU itself is back to a plain ADD
  assign knownCmd = (funct[4:1] == CMD_ADD) | (funct[4:1] == CMD_SUB) |
                    (funct[4:1] == CMD_AND) | (funct[4:1] == CMD_ORR);
  assign noWrite  = (op == OP_DP) & ~knownCmd;

  assign immSrc    = (op == 2'b11) ? 2'b00 : op;
  assign regSrc[0] = (op == OP_BR);
  assign regSrc[1] = (op == OP_MEM);

  logic pcs;
  assign pcs = branch | (regW & (rd == 4'hF));

  multicycle_control_cond #(
    .FLAGS_RESET(FLAGS_RESET)
  ) u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .aluFlags (aluFlags),
    .flagW    (flagW),
    .condLoad (curState == S_DECODE),
    .condClear(curState == S_FETCH),
    .nextPC   (nextPC & ~reset),
    .pcs      (pcs),
    .regW     (regW),
    .memW     (memW),
    .noWrite  (noWrite),
    .pcWrite  (pcWrite),
    .regWrite (regWrite),
    .memWrite (memWrite)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; each scenario walks an
// instruction through its states and compares the full output vector per cycle.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr;
  logic [3:0]  aluFlags;
  logic        pcWrite, irWrite, memWrite, regWrite, adrSrc, aluSrcA;
  logic [1:0]  aluSrcB, resultSrc, aluControl, immSrc, regSrc;

  int compared   = 0;
  int mismatched = 0;

  multicycle_control #(.FLAGS_RESET(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .aluFlags  (aluFlags),
    .pcWrite   (pcWrite),
    .irWrite   (irWrite),
    .memWrite  (memWrite),
    .regWrite  (regWrite),
    .adrSrc    (adrSrc),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .resultSrc (resultSrc),
    .aluControl(aluControl),
    .immSrc    (immSrc),
    .regSrc    (regSrc)
  );

  always #5 clk = ~clk;

  logic [15:0] outs;
  assign outs = {pcWrite, irWrite, memWrite, regWrite, adrSrc, aluSrcA,
                 aluSrcB, resultSrc, aluControl, immSrc, regSrc};

  function automatic logic [15:0] mk(input logic pc, input logic ir, input logic mw,
                                     input logic rw, input logic adr, input logic a,
                                     input logic [1:0] b, input logic [1:0] res,
                                     input logic [1:0] alu, input logic [1:0] imm,
                                     input logic [1:0] rs);
    return {pc, ir, mw, rw, adr, a, b, res, alu, imm, rs};
  endfunction

  // instruction fields: {cond, op, funct, Rn, Rd}
  function automatic logic [19:0] enc(input logic [3:0] cond, input logic [1:0] op,
                                      input logic [5:0] funct, input logic [3:0] rd);
    return {cond, op, funct, 4'h2, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] rstVec;
    rstVec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
    reset = 1'b1;
    instr = 20'h0;
    aluFlags = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (outs !== rstVec) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cyc%0d: got %b want %b", i, outs, rstVec);
      end
      compared++;
    end
    reset = 1'b0;
    #1;
    if (outs !== mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0)) begin
      mismatched++;
      $display("[TB] FAIL reset_first_fetch: got %b want 1100011010000000", outs);
    end
    compared++;
    if (dut.u_cond.flags !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b want 0000", dut.u_cond.flags);
    end
    compared++;
  endtask

  task automatic test_add_imm();
    logic [15:0] exp [$];
    instr = enc(4'hE, 2'b00, 6'b101000, 4'h1);
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL add_imm cyc%0d: got %b want %b", i, outs, exp[i]);
      end
      compared++;
    end
  endtask

  task automatic test_subs_beq(input logic [3:0] subFlags, input logic taken);
    logic [15:0] exp [$];
    instr = enc(4'hE, 2'b00, 6'b000101, 4'h1);
    aluFlags = subFlags;
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL subs cyc%0d: got %b want %b", i, outs, exp[i]);
      end
      compared++;
    end
    if (dut.u_cond.flags !== subFlags) begin
      mismatched++;
      $display("[TB] FAIL subs_flags: got %b want %b", dut.u_cond.flags, subFlags);
    end
    compared++;
    exp.delete();
    instr = enc(4'h0, 2'b10, 6'b000000, 4'h0);
    aluFlags = 4'h0;
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd2, 2'd1));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd2, 2'd1));
    exp.push_back(mk(taken, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1));
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd2, 2'd1));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL beq_taken%0d cyc%0d: got %b want %b", taken, i, outs, exp[i]);
      end
      compared++;
    end
  endtask

  task automatic test_ldr_str();
    logic [15:0] exp [$];
    instr = enc(4'hE, 2'b01, 6'b011001, 4'h3);
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL ldr cyc%0d: got %b want %b", i, outs, exp[i]);
      end
      compared++;
    end
    exp.delete();
    instr = enc(4'hE, 2'b01, 6'b011000, 4'h3);
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL str cyc%0d: got %b want %b", i, outs, exp[i]);
      end
      compared++;
    end
  endtask

  // register-form DP instruction whose ALUWB outcome and final flags are given
  task automatic test_dp_reg(input string name, input logic [3:0] cond, input logic [5:0] funct,
                             input logic [3:0] rd, input logic [3:0] flagsIn,
                             input logic [1:0] aluExp, input logic pcWb, input logic regWb,
                             input logic [3:0] flagsExp);
    logic [15:0] exp [$];
    instr = enc(cond, 2'b00, funct, rd);
    aluFlags = flagsIn;
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 0, 0, 0, funct[5] ? 2'd1 : 2'd0, 2'd0, aluExp, 2'd0, 2'd0));
    exp.push_back(mk(pcWb, 0, 0, regWb, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL %s cyc%0d: got %b want %b", name, i, outs, exp[i]);
      end
      compared++;
    end
    if (dut.u_cond.flags !== flagsExp) begin
      mismatched++;
      $display("[TB] FAIL %s_flags: got %b want %b", name, dut.u_cond.flags, flagsExp);
    end
    compared++;
    aluFlags = 4'h0;
  endtask

  task automatic test_nop();
    logic [15:0] exp [$];
    instr = enc(4'hE, 2'b11, 6'b000000, 4'h0);
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL nop cyc%0d: got %b want %b", i, outs, exp[i]);
      end
      compared++;
    end
  endtask

  task automatic test_reset_midinstr();
    logic [15:0] exp [$];
    instr = enc(4'hE, 2'b01, 6'b011001, 4'h3);
    aluFlags = 4'hF;
    #1;
    exp.push_back(mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2));
    exp.push_back(mk(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2));
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) tick();
      if (outs !== exp[i]) begin
        mismatched++;
        $display("[TB] FAIL rst_mid cyc%0d: got %b want %b", i, outs, exp[i]);
      end
      compared++;
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick(); else #1;
      if (outs !== mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2)) begin
        mismatched++;
        $display("[TB] FAIL rst_mid_hold%0d: got %b want 0000011010000110", i, outs);
      end
      compared++;
    end
    reset = 1'b0;
    #1;
    if (outs !== mk(1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2)) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_fetch: got %b want 1100011010000110", outs);
    end
    compared++;
    if (dut.u_cond.flags !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_flags: got %b want 0000", dut.u_cond.flags);
    end
    compared++;
    tick();
    if (outs !== mk(0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2)) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_decode: got %b want 0000011010000110", outs);
    end
    compared++;
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_subs_beq(4'b0100, 1'b1);
    test_subs_beq(4'b0000, 1'b0);
    test_ldr_str();
    // CMP sets Z,C; the NE-conditional ADDS that follows must neither write nor touch flags
    test_dp_reg("cmp",     4'hE, 6'b010101, 4'h1, 4'b0110, 2'd1, 1'b0, 1'b0, 4'b0110);
    test_dp_reg("addne",   4'h1, 6'b001001, 4'h1, 4'b1001, 2'd0, 1'b0, 1'b0, 4'b0110);
    test_dp_reg("eors",    4'hE, 6'b000011, 4'h1, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b0110);
    test_dp_reg("add_nv",  4'hF, 6'b101001, 4'h1, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b0110);
    test_dp_reg("add_pc",  4'hE, 6'b101000, 4'hF, 4'b0000, 2'd0, 1'b1, 1'b1, 4'b0110);
    test_dp_reg("orrs",    4'hE, 6'b011001, 4'h1, 4'b1011, 2'd3, 1'b0, 1'b1, 4'b1010);
    test_nop();
    test_reset_midinstr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
